mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: CNT_WIDTH, default 16, width of each grant counter.
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-003 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- i_read  in  1  icache line read request
- i_address  in  16  icache line address (lc3b_word)
- i_rdata  out  128  line data to icache (lc3b_line)
- i_resp  out  1  icache transaction complete
- d_read  in  1  dcache line read request
- d_write  in  1  dcache line write request
- d_address  in  16  dcache line address
- d_wdata  in  128  dcache writeback line
- d_rdata  out  128  line data to dcache
- d_resp  out  1  dcache transaction complete
- mem_read  out  1  shared memory read strobe
- mem_write  out  1  shared memory write strobe
- mem_address  out  16  shared memory address
- mem_wdata  out  128  shared memory write line
- mem_rdata  in  128  shared memory read line
- mem_resp  in  1  shared memory transaction complete
- cnt_clear  in  1  clear both grant counters
- i_grant_cnt  out  CNT_WIDTH  icache grants taken
- d_grant_cnt  out  CNT_WIDTH  dcache grants taken

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, SERVE_I, SERVE_D.
REQ-005 In IDLE with only i_read high, next state SHALL be SERVE_I; with only d_read or d_write high, next state SHALL be SERVE_D; with no request, the FSM SHALL stay in IDLE.
REQ-006 On a simultaneous icache and dcache request in IDLE, the FSM SHALL grant the requester not granted last, per a 1-bit last_grant register; reset SHALL leave last_grant = I, so dcache wins the first tie.
REQ-007 last_grant SHALL update on every IDLE->SERVE_x transition.
REQ-008 In SERVE_I: mem_read = 1, mem_write = 0, mem_address = i_address.
REQ-009 In SERVE_D: mem_read = d_read, mem_write = d_write, mem_address = d_address, mem_wdata = d_wdata.
REQ-010 In IDLE, mem_read and mem_write SHALL be 0; mem_address and mem_wdata are don't-care.
REQ-011 i_resp SHALL equal mem_resp AND (state == SERVE_I); d_resp SHALL equal mem_resp AND (state == SERVE_D).
REQ-012 i_rdata and d_rdata SHALL both carry mem_rdata combinationally.
REQ-013 From a SERVE state, the cycle mem_resp is 1 SHALL transition to IDLE.
REQ-014 Latency SHALL be as follows:
- a request sampled in IDLE at edge N drives memory strobes from cycle N+1;
- back-to-back transactions have exactly one IDLE cycle between mem_resp and the next strobe.
REQ-015 A grant SHALL be held until mem_resp, even if the requester deasserts its request; mem_resp outside a SERVE state SHALL be ignored.
REQ-016 If d_read and d_write are both high, the block SHALL forward both unchanged (caller error; not arbitrated).
REQ-017 Grant counter behaviour:
- each IDLE->SERVE_x transition SHALL increment the matching counter;
- counters SHALL saturate at all-ones;
- cnt_clear SHALL zero both counters and take priority over an increment in the same cycle.

Reset
REQ-018 Reset SHALL override all other inputs on the same edge.
REQ-019 After reset: state = IDLE, last_grant = I, both counters = 0, mem_read = mem_write = 0, i_resp = d_resp = 0.
REQ-020 Reset during a SERVE state SHALL abandon the transaction; strobes SHALL drop on the cycle after the reset edge and no resp SHALL be forwarded.

Structure
REQ-021 lc3b_types SHALL define lc3b_line (128-bit) and the arbiter state enum; lc3b_word SHALL be reused for addresses.
REQ-022 The block SHALL contain one sub-module, arbiter_counter: a saturating CNT_WIDTH counter with clear, instantiated twice.
REQ-023 Output muxing SHALL be combinational from the registered state; no datapath registers SHALL be added.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- i_read only, addr 0x1230; mem_resp after 3 cycles with rdata 0xA5..A5 -> mem_address 0x1230, i_resp for 1 cycle, d_resp = 0, i_grant_cnt = 1.
- i_read and d_write together from reset, d_address 0x4000 -> SERVE_D first with mem_write = 1; then SERVE_I with exactly one IDLE cycle between.
- Both requests held continuously for 4 transactions -> grants alternate D, I, D, I; counters 2/2.
- Reset asserted mid SERVE_D -> mem_write = 0 the next cycle, state IDLE, a later mem_resp produces no d_resp.
- Counters preset near all-ones with CNT_WIDTH = 4, 20 icache grants -> i_grant_cnt stays 15; cnt_clear together with a grant -> 0.
- mem_resp pulsed while IDLE -> i_resp = d_resp = 0, no state change.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/line types and arbiter state encoding
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    // last_grant encoding: 0 = icache, 1 = dcache
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/arbiter_counter.sv
// rtl/arbiter_counter.sv - saturating grant counter with synchronous clear
module arbiter_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter onto one shared line memory port
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_read,
    input  lc3b_word             i_address,
    output lc3b_line             i_rdata,
    output logic                 i_resp,
    input  logic                 d_read,
    input  logic                 d_write,
    input  lc3b_word             d_address,
    input  lc3b_line             d_wdata,
    output lc3b_line             d_rdata,
    output logic                 d_resp,
    output logic                 mem_read,
    output logic                 mem_write,
    output lc3b_word             mem_address,
    output lc3b_line             mem_wdata,
    input  lc3b_line             mem_rdata,
    input  logic                 mem_resp,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] i_grant_cnt,
    output logic [CNT_WIDTH-1:0] d_grant_cnt
);

    arb_state_t state;
    arb_state_t next_state;
    logic       last_grant;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;

    assign d_req = d_read | d_write;

    // On a tie the side that did not win last time goes first.
    assign grant_d = (state == ARB_IDLE) && d_req && (!i_read || (last_grant == GRANT_I));
    assign grant_i = (state == ARB_IDLE) && i_read && !grant_d;

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: begin
                if (grant_d) begin
                    next_state = ARB_SERVE_D;
                end else if (grant_i) begin
                    next_state = ARB_SERVE_I;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (mem_resp) begin
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_I;
        end else begin
            state <= next_state;
            if (grant_d) begin
                last_grant <= GRANT_D;
            end else if (grant_i) begin
                last_grant <= GRANT_I;
            end
        end
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = d_address;
        mem_wdata   = d_wdata;
        case (state)
            ARB_SERVE_I: begin
                mem_read    = 1'b1;
                mem_address = i_address;
            end
            ARB_SERVE_D: begin
                mem_read  = d_read;
                mem_write = d_write;
            end
            default: ;
        endcase
    end

    assign i_resp  = mem_resp && (state == ARB_SERVE_I);
    assign d_resp  = mem_resp && (state == ARB_SERVE_D);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    arbiter_counter #(.CNT_WIDTH(CNT_WIDTH)) u_i_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (grant_i),
        .count (i_grant_cnt)
    );

    arbiter_counter #(.CNT_WIDTH(CNT_WIDTH)) u_d_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (grant_d),
        .count (d_grant_cnt)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed checks of mem_arbiter against a transaction model
module tb_mem_arbiter;

    localparam int CW = 4;
    localparam int CMAX = 15;

    logic           clk = 1'b0;
    logic           reset;
    logic           i_read;
    logic [15:0]    i_address;
    logic [127:0]   i_rdata;
    logic           i_resp;
    logic           d_read;
    logic           d_write;
    logic [15:0]    d_address;
    logic [127:0]   d_wdata;
    logic [127:0]   d_rdata;
    logic           d_resp;
    logic           mem_read;
    logic           mem_write;
    logic [15:0]    mem_address;
    logic [127:0]   mem_wdata;
    logic [127:0]   mem_rdata;
    logic           mem_resp;
    logic           cnt_clear;
    logic [CW-1:0]  i_grant_cnt;
    logic [CW-1:0]  d_grant_cnt;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: who owns the memory port, who won last, grant tallies.
    int owner = 0;       // 0 none, 1 icache, 2 dcache
    int last_winner = 1; // 1 icache, 2 dcache
    int icnt = 0;
    int dcnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .cnt_clear   (cnt_clear),
        .i_grant_cnt (i_grant_cnt),
        .d_grant_cnt (d_grant_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic exp_rd;
        logic exp_wr;
        exp_rd = (owner == 1) ? 1'b1 : (owner == 2) ? d_read : 1'b0;
        exp_wr = (owner == 2) ? d_write : 1'b0;
        chk("mem_read", mem_read, exp_rd);
        chk("mem_write", mem_write, exp_wr);
        if (owner == 1) chk("mem_address_i", mem_address, i_address);
        if (owner == 2) begin
            chk("mem_address_d", mem_address, d_address);
            chk("mem_wdata", mem_wdata, d_wdata);
        end
        chk("i_resp", i_resp, mem_resp && owner == 1);
        chk("d_resp", d_resp, mem_resp && owner == 2);
        chk("i_rdata", i_rdata, mem_rdata);
        chk("d_rdata", d_rdata, mem_rdata);
        chk("i_grant_cnt", i_grant_cnt, icnt);
        chk("d_grant_cnt", d_grant_cnt, dcnt);
    endtask

    task automatic model_edge();
        int winner;
        winner = 0;
        if (reset) begin
            owner = 0;
            last_winner = 1;
            icnt = 0;
            dcnt = 0;
            return;
        end
        if (owner == 0) begin
            if (i_read && (d_read || d_write)) winner = (last_winner == 1) ? 2 : 1;
            else if (i_read) winner = 1;
            else if (d_read || d_write) winner = 2;
            if (winner != 0) begin
                owner = winner;
                last_winner = winner;
                if (winner == 1 && icnt < CMAX) icnt++;
                if (winner == 2 && dcnt < CMAX) dcnt++;
            end
        end else if (mem_resp) begin
            owner = 0;
        end
        if (cnt_clear) begin
            icnt = 0;
            dcnt = 0;
        end
    endtask

    // Check combinational outputs mid-cycle, then advance the model across the edge.
    task automatic tick();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        i_read = 0; d_read = 0; d_write = 0; mem_resp = 0; cnt_clear = 0; reset = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        i_address = 16'h1230;
        d_address = 16'h4000;
        d_wdata   = {4{32'hDEADBEEF}};
        mem_rdata = '0;
        reset = 1;
        @(posedge clk);
        model_edge();
        #1;
        reset = 0;
        #1;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_i_resp", i_resp, 1'b0);
        chk("rst_d_resp", d_resp, 1'b0);
        chk("rst_i_cnt", i_grant_cnt, 0);
        chk("rst_d_cnt", d_grant_cnt, 0);

        // icache read only, response after three serve cycles
        i_read = 1;
        tick();
        i_read = 0;
        #1 chk("s1_addr", mem_address, 16'h1230);
        chk("s1_read", mem_read, 1'b1);
        tick();
        tick();
        mem_resp = 1;
        mem_rdata = {16{8'hA5}};
        #1 chk("s1_i_resp", i_resp, 1'b1);
        chk("s1_d_resp", d_resp, 1'b0);
        chk("s1_rdata", i_rdata, {16{8'hA5}});
        tick();
        mem_resp = 0;
        #1 chk("s1_i_resp_drop", i_resp, 1'b0);
        chk("s1_icnt", i_grant_cnt, 1);
        tick();

        // tie from reset, then steady contention: D, I, D, I with one idle cycle between
        do_reset();
        i_read = 1;
        d_write = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            if (k % 2 == 0) begin
                chk("alt_d_write", mem_write, 1'b1);
                chk("alt_d_read", mem_read, 1'b0);
                chk("alt_d_addr", mem_address, 16'h4000);
            end else begin
                chk("alt_i_read", mem_read, 1'b1);
                chk("alt_i_write", mem_write, 1'b0);
                chk("alt_i_addr", mem_address, 16'h1230);
            end
            mem_resp = 1;
            tick();
            mem_resp = 0;
            #1 chk("alt_gap", {mem_read, mem_write}, 2'b00);
        end
        chk("alt_icnt", i_grant_cnt, 2);
        chk("alt_dcnt", d_grant_cnt, 2);
        idle_inputs();
        tick();

        // reset in the middle of a dcache write
        do_reset();
        d_write = 1;
        tick();
        #1 chk("rst_mid_write_on", mem_write, 1'b1);
        d_write = 0;
        reset = 1;
        tick();
        reset = 0;
        #1 chk("rst_mid_write_off", mem_write, 1'b0);
        mem_resp = 1;
        #1 chk("rst_mid_no_dresp", d_resp, 1'b0);
        tick();
        mem_resp = 0;
        #1 chk("rst_mid_idle", {mem_read, mem_write}, 2'b00);

        // saturation of the icache counter, then clear racing a grant
        do_reset();
        for (int k = 0; k < 20; k++) begin
            i_read = 1;
            tick();
            i_read = 0;
            mem_resp = 1;
            tick();
            mem_resp = 0;
        end
        chk("sat_icnt", i_grant_cnt, 15);
        i_read = 1;
        cnt_clear = 1;
        tick();
        cnt_clear = 0;
        i_read = 0;
        #1 chk("clear_wins", i_grant_cnt, 0);
        chk("clear_grant_held", mem_read, 1'b1);
        mem_resp = 1;
        tick();
        mem_resp = 0;

        // spurious response while idle
        tick();
        mem_resp = 1;
        #1 chk("idle_resp_i", i_resp, 1'b0);
        chk("idle_resp_d", d_resp, 1'b0);
        tick();
        mem_resp = 0;
        #1 chk("idle_resp_state", {mem_read, mem_write}, 2'b00);
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 79) == 0);
            cnt_clear = ($urandom_range(0, 39) == 0);
            i_read    = $urandom_range(0, 1);
            d_read    = ($urandom_range(0, 2) == 0);
            d_write   = ($urandom_range(0, 2) == 0);
            mem_resp  = ($urandom_range(0, 2) == 0);
            i_address = 16'($urandom);
            d_address = 16'($urandom);
            d_wdata   = {$urandom, $urandom, $urandom, $urandom};
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
